// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile
//   APB4 completer backed by a small word-addressed register file.
//   Word 0 is a read-only ID register; every other word is read/write with
//   byte strobes. All bus outputs come straight from flops.
//
//   Optional feature macro: APB_SLAVE_WAIT_EN
//     defined   -> WAIT_CYCLES wait states are inserted into every transfer
//     undefined -> no wait counter is built, every transfer completes in the
//                  first penable cycle
//
// Ports
//   pclk, preset_n   clock (rising edge), asynchronous active-low reset
//   psel, penable    APB select / access-phase qualifiers
//   pwrite           1 = write, 0 = read
//   paddr            byte address, word index = paddr[ADDR_WIDTH-1:2]
//   pwdata, pstrb    write data and byte strobes
//   pprot            accepted and ignored
//   prdata           read data, non-zero only in the completion cycle
//   pready, pslverr  completion and error, both high for one cycle at most

module apb_slave_regfile #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [2:0]              pprot,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int NB    = DATA_WIDTH / 8;

    // The state names the phase the bus is in during the current cycle.
    // The setup cycle itself is observed while in IDLE (or ACCESS for a
    // back-to-back transfer); ACCESS is the cycle in which pready is high.
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_ACCESS} state_t;

    state_t                  state_q, state_d;
    logic                    wr_q, wr_d;
    logic                    err_q, err_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]           strb_q, strb_d;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    commit;

`ifdef APB_SLAVE_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic unused_ok;
`ifdef APB_SLAVE_WAIT_EN
    assign unused_ok = ^{pprot, paddr[1:0]};
`else
    assign unused_ok = ^{pprot, paddr[1:0], (WAIT_CYCLES != 0)};
`endif

    // Next-state and transfer-capture logic. A new setup is captured in the
    // cycle it is seen so that a zero-wait transfer can raise the registered
    // pready in the very first penable cycle. The counter is preloaded with
    // WAIT_CYCLES-1 because the SETUP cycle already counts as one wait state.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
`ifdef APB_SLAVE_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE, S_ACCESS: begin
                state_d = S_IDLE;
                if (psel && !penable) begin
                    wr_d    = pwrite;
                    idx_d   = paddr[ADDR_WIDTH-1:2];
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                    err_d   = (int'(paddr[ADDR_WIDTH-1:2]) >= NUM_REGS) ||
                              (pwrite && (paddr[ADDR_WIDTH-1:2] == '0));
`ifdef APB_SLAVE_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_SETUP;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = S_ACCESS;
                    end
`else
                    state_d = S_ACCESS;
`endif
                end else if ((state_q == S_IDLE) && psel && penable) begin
                    // Access phase with no preceding setup: this cycle stands
                    // in for the setup and the next one completes with error.
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ACCESS;
                end
            end
`ifdef APB_SLAVE_WAIT_EN
            S_SETUP: begin
                if (!psel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (penable) begin
                    if (cnt_q != '0) begin
                        state_d = S_WAIT;
                        cnt_d   = cnt_q - 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured-transfer registers.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
`ifdef APB_SLAVE_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
`ifdef APB_SLAVE_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Read mux on the index that is about to complete, so prdata can be
    // registered on the edge that enters ACCESS.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(idx_d) == i) rd_word = regs[i];
        end
    end

    // Registered bus outputs: everything is zero except in the ACCESS cycle.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            pready  <= (state_d == S_ACCESS);
            pslverr <= (state_d == S_ACCESS) && err_d;
            prdata  <= ((state_d == S_ACCESS) && !err_d && !wr_d) ? rd_word : '0;
        end
    end

    // A write lands on the edge that closes the ACCESS cycle, and only while
    // the master still selects us, so a reset or deselect first discards it.
    assign commit = (state_q == S_ACCESS) && wr_q && !err_q && psel;

    // Register file; word 0 is never written because such writes are errors.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            regs[0] <= ID_VALUE;
            for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (int'(idx_q) == i) begin
                    for (int b = 0; b < NB; b++) begin
                        if (strb_q[b]) regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule
